// File: rtl/run_scorer.sv
// Per-frame score keeper and game-over controller: BCD coin scoring with
// saturation, retained high score, and a timed DEAD hold with blink output.
module run_scorer #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned DEAD_HOLD  = 120,
    parameter int unsigned BLINK_HALF = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  play,
    input  logic [2:0]            coin_hit,
    input  logic [3:0]            fatal_hit,
    input  logic                  restart,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   high_score,
    output logic                  game_over,
    output logic                  blink,
    output logic [1:0]            state_o
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned HW = (DEAD_HOLD > 1) ? $clog2(DEAD_HOLD) : 1;
    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [HW-1:0] HOLD_MAX  = HW'(DEAD_HOLD - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);
    localparam logic [W-1:0]  ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2,
        ST_BAD  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    score_q, score_d;
    logic [W-1:0]    high_q, high_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic            blink_q, blink_d;
    logic            go_q, go_d;

    logic [1:0]      n_coins;
    logic [W-1:0]    sat_sum;
    logic [W-1:0]    new_high;
    logic            fatal_any;

    assign fatal_any = |fatal_hit;
    assign n_coins   = 2'(coin_hit[0]) + 2'(coin_hit[1]) + 2'(coin_hit[2]);

    // Ripple BCD add of 0..3; a carry out of the top digit means overflow.
    always_comb begin
        logic [4:0]   dsum;
        logic [1:0]   carry;
        logic [W-1:0] sum_bcd;
        carry   = n_coins;
        sum_bcd = '0;
        dsum    = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dsum = {1'b0, score_q[4*i +: 4]} + {3'b000, carry};
            if (dsum > 5'd9) begin
                sum_bcd[4*i +: 4] = 4'(dsum - 5'd10);
                carry             = 2'd1;
            end else begin
                sum_bcd[4*i +: 4] = dsum[3:0];
                carry             = 2'd0;
            end
        end
        sat_sum = (carry != 2'd0) ? ALL_NINES : sum_bcd;
    end

    // Valid BCD orders the same as plain binary, so a vector compare suffices.
    assign new_high = (sat_sum > high_q) ? sat_sum : high_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            high_q  <= '0;
            hold_q  <= '0;
            bcnt_q  <= '0;
            blink_q <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            high_q  <= high_d;
            hold_q  <= hold_d;
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
            go_q    <= go_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (play) state_d = ST_RUN;
            ST_RUN: begin
                if (fatal_any)  state_d = ST_DEAD;
                else if (!play) state_d = ST_IDLE;
            end
            ST_DEAD: if (restart && (hold_q == HOLD_MAX)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        score_d = score_q;
        high_d  = high_q;
        hold_d  = hold_q;
        bcnt_d  = bcnt_q;
        blink_d = blink_q;
        go_d    = (state_d == ST_DEAD);
        case (state_q)
            ST_IDLE: if (play) score_d = '0;
            ST_RUN: begin
                score_d = sat_sum;
                if (fatal_any || !play) high_d = new_high;
                if (fatal_any) begin
                    hold_d  = '0;
                    bcnt_d  = '0;
                    blink_d = 1'b1;
                end
            end
            ST_DEAD: begin
                if (state_d == ST_IDLE) begin
                    hold_d  = '0;
                    bcnt_d  = '0;
                    blink_d = 1'b0;
                end else begin
                    if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
                    if (bcnt_q == BLINK_MAX) begin
                        bcnt_d  = '0;
                        blink_d = ~blink_q;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                hold_d  = '0;
                bcnt_d  = '0;
                blink_d = 1'b0;
            end
        endcase
    end

    assign score      = score_q;
    assign high_score = high_q;
    assign game_over  = go_q;
    assign blink      = blink_q;
    assign state_o    = state_q;

endmodule

// File: doc/run_scorer.md
Name: run_scorer

Overview:
- Frame-rate scoring and game-over controller; sits directly downstream of the coin and obstacle collision detectors.
- Consumes per-lane coin-hit pulses and fatal-hit pulses. Produces a saturating BCD score, a retained BCD high score, and a game-over flag with a timed hold and a blink output.
- The overlay layer and the top-level state machine consume its outputs.
- Clocked once per frame, in the vsync domain.

Parameters:
- DIGITS, 4, number of BCD digits in score and high score (1..8).
- DEAD_HOLD, 120, frames in DEAD before restart is accepted (>=1).
- BLINK_HALF, 16, frames per half-period of the blink output (>=1).

Ports:
- clk  in  1  frame clock (vsync domain); all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- play  in  1  high while top-level is in normal game play.
- coin_hit  in  3  one bit per coin lane (left, middle, right); each bit is a one-cycle pulse; several may be high together.
- fatal_hit  in  4  one bit per obstacle detector; any bit high is a fatal collision.
- restart  in  1  level; request to leave DEAD.
- score  out  4*DIGITS  current score, BCD, digit 0 in bits [3:0].
- high_score  out  4*DIGITS  best score since reset, BCD.
- game_over  out  1  high in DEAD.
- blink  out  1  toggles every BLINK_HALF frames in DEAD; 0 otherwise.
- state_o  out  2  encoded state: IDLE=0, RUN=1, DEAD=2.

Behaviour:
- Reset (async, rst_n=0): state IDLE; score=0; high_score=0; game_over=0; blink=0; hold and blink counters=0. Outputs take these values immediately, with no clock needed.
- All outputs are registered; one-cycle latency from input sample to output.
- IDLE:
  - play=1 -> RUN, and score is cleared to 0 on the same edge.
  - Coin and fatal inputs are ignored.
- RUN:
  - Each cycle, n = popcount(coin_hit), range 0..3.
  - score <= score + n as a BCD ripple add; each digit is corrected +6 on >9 and carries to the next digit.
  - If the result would exceed all-9s, score saturates at all-9s (e.g. 9999), with no wrap.
  - If any fatal_hit bit is set -> DEAD. Coins in the same cycle are still added before the transition.
  - On that same edge, high_score <= max(high_score, new score), compared in BCD magnitude.
  - play=0 with no fatal -> IDLE; high_score is updated the same way and score is retained.
  - Fatal has priority over play=0.
- DEAD:
  - game_over=1.
  - Hold counter runs from 0 to DEAD_HOLD-1, then saturates.
  - blink toggles every BLINK_HALF frames, starting at 1 on DEAD entry.
  - Coin and fatal inputs are ignored; score is frozen.
  - restart=1 with the counter saturated -> IDLE. On that edge game_over=0, blink=0, counters=0, and score is retained.
  - restart before the hold expires is ignored; it is not remembered.
- state_o value 3 is unreachable. If it is entered (e.g. by an SEU), the next edge goes to IDLE.
- rst_n asserted mid-operation (any state, any counter value) returns everything to reset values asynchronously; high_score is cleared.
- No combinational path from any input to any output.

Test Plan:
1. Reset, play=1 for 1 cycle -> state_o=1 next edge, score=0000; hold play=1, pulse coin_hit=3'b101 once -> score=0002.
2. In RUN, score=0009, coin_hit=3'b111 -> score=0012 (BCD carry); score=0098, coin_hit=3'b011 -> 0100.
3. Score=9998, coin_hit=3'b111 -> score=9999; repeat -> stays 9999.
4. Score=0041, high_score=0030, coin_hit=3'b010 and fatal_hit=4'b0100 same cycle -> score=0042, high_score=0042, game_over=1, blink=1; next game ending at 0010 -> high_score stays 0042.
5. In DEAD, restart=1 at frame 50 -> stays DEAD; restart=1 at frame DEAD_HOLD -> IDLE, game_over=0, blink=0, score retained. blink toggles at frames 16, 32, 48 of DEAD.
6. rst_n=0 asynchronously mid-DEAD with high_score=0042 -> all outputs 0 before the next clk edge; fatal_hit pulses in IDLE -> no state change.
